// File: rtl/xs_sdr_rom_arbiter.sv
// Five-client SDRAM ROM read arbiter with data holding registers and read timeout.
// Optional per-client last-address hit cache enabled by XS_SDR_HITCACHE_EN.
module xs_sdr_rom_arbiter #(
   parameter int          NCLI     = 5,
   parameter int          RR       = 0,
   parameter int          TMO      = 255,
   parameter logic [15:0] TMO_DATA = 16'hFFFF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NCLI*25-1:0] cli_addr,
   input  logic [NCLI-1:0]    cli_req,
   output logic [NCLI-1:0]    cli_rdy,
   output logic [NCLI*16-1:0] cli_dout,
   output logic [24:0]        ram_addr,
   output logic               ram_req,
   input  logic               ram_rdy,
   input  logic [15:0]        ram_data,
   output logic               busy,
   output logic               tmo_flag
);

   localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   win_q, win_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [24:0]     ram_addr_q, ram_addr_d;
   logic            ram_req_q, ram_req_d;
   logic [NCLI-1:0] rdy_q, rdy_d;
   logic [15:0]     dout_q [NCLI];
   logic [15:0]     dout_d [NCLI];
   logic            tmo_q, tmo_d;

   logic [24:0]     addr_a [NCLI];
   logic            found;
   logic [IW-1:0]   pick;
   logic            hit;
   int              sidx;

`ifdef XS_SDR_HITCACHE_EN
   logic [24:0]     tag_q [NCLI];
   logic [24:0]     tag_d [NCLI];
   logic [NCLI-1:0] vld_q, vld_d;
`endif

   for (genvar g = 0; g < NCLI; g++) begin : g_cli
      assign addr_a[g]            = cli_addr[25*g +: 25];
      assign cli_dout[16*g +: 16] = dout_q[g];
   end

   // Winner selection: lowest index, or rotating start after the last grant.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sidx  = 0;
      if (RR != 0) begin
         for (int k = 1; k <= NCLI; k++) begin
            sidx = (int'(ptr_q) + k) % NCLI;
            if (!found && cli_req[sidx[IW-1:0]]) begin
               found = 1'b1;
               pick  = sidx[IW-1:0];
            end
         end
      end else begin
         for (int i = 0; i < NCLI; i++) begin
            if (!found && cli_req[i]) begin
               found = 1'b1;
               pick  = IW'(i);
            end
         end
      end
   end

`ifdef XS_SDR_HITCACHE_EN
   assign hit = vld_q[pick] && (tag_q[pick] == addr_a[pick]);
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      ram_addr_d = ram_addr_q;
      ram_req_d  = ram_req_q;
      rdy_d      = '0;
      dout_d     = dout_q;
      tmo_d      = tmo_q;
`ifdef XS_SDR_HITCACHE_EN
      tag_d      = tag_q;
      vld_d      = vld_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d = pick;
               ptr_d = pick;
               cnt_d = '0;
               if (hit) begin
                  rdy_d[pick] = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  ram_addr_d = addr_a[pick];
                  ram_req_d  = 1'b1;
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (ram_rdy) begin
               dout_d[win_q] = ram_data;
               rdy_d[win_q]  = 1'b1;
               ram_req_d     = 1'b0;
               state_d       = S_DONE;
`ifdef XS_SDR_HITCACHE_EN
               tag_d[win_q]  = ram_addr_q;
               vld_d[win_q]  = 1'b1;
`endif
            end else if (cnt_q == TMO_LAST) begin
               dout_d[win_q] = TMO_DATA;
               rdy_d[win_q]  = 1'b1;
               tmo_d         = 1'b1;
               ram_req_d     = 1'b0;
               state_d       = S_DONE;
`ifdef XS_SDR_HITCACHE_EN
               vld_d[win_q]  = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         win_q      <= '0;
         ptr_q      <= IW'(NCLI - 1);
         cnt_q      <= '0;
         ram_addr_q <= '0;
         ram_req_q  <= 1'b0;
         rdy_q      <= '0;
         tmo_q      <= 1'b0;
         for (int i = 0; i < NCLI; i++) begin
            dout_q[i] <= '0;
         end
`ifdef XS_SDR_HITCACHE_EN
         for (int i = 0; i < NCLI; i++) begin
            tag_q[i] <= '0;
         end
         vld_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         ram_addr_q <= ram_addr_d;
         ram_req_q  <= ram_req_d;
         rdy_q      <= rdy_d;
         tmo_q      <= tmo_d;
         dout_q     <= dout_d;
`ifdef XS_SDR_HITCACHE_EN
         tag_q      <= tag_d;
         vld_q      <= vld_d;
`endif
      end
   end

   assign cli_rdy  = rdy_q;
   assign ram_addr = ram_addr_q;
   assign ram_req  = ram_req_q;
   assign busy     = (state_q != S_IDLE);
   assign tmo_flag = tmo_q;

endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// Directed bench for xs_sdr_rom_arbiter: fixed-priority instance plus a
// round-robin instance; hit-cache checks run when XS_SDR_HITCACHE_EN is set.
module tb_xs_sdr_rom_arbiter;

   logic         clk = 1'b0;
   logic         rst;

   logic [124:0] d_cli_addr;
   logic [4:0]   d_cli_req;
   logic [4:0]   d_cli_rdy;
   logic [79:0]  d_cli_dout;
   logic [24:0]  d_ram_addr;
   logic         d_ram_req;
   logic         d_ram_rdy;
   logic [15:0]  d_ram_data;
   logic         d_busy;
   logic         d_tmo;

   logic [124:0] r_cli_addr;
   logic [4:0]   r_cli_req;
   logic [4:0]   r_cli_rdy;
   logic [79:0]  r_cli_dout;
   logic [24:0]  r_ram_addr;
   logic         r_ram_req;
   logic         r_ram_rdy;
   logic [15:0]  r_ram_data;
   logic         r_busy;
   logic         r_tmo;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   xs_sdr_rom_arbiter #(.RR(0)) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .cli_addr (d_cli_addr),
      .cli_req  (d_cli_req),
      .cli_rdy  (d_cli_rdy),
      .cli_dout (d_cli_dout),
      .ram_addr (d_ram_addr),
      .ram_req  (d_ram_req),
      .ram_rdy  (d_ram_rdy),
      .ram_data (d_ram_data),
      .busy     (d_busy),
      .tmo_flag (d_tmo)
   );

   xs_sdr_rom_arbiter #(.RR(1)) u_rr (
      .CLK      (clk),
      .RST      (rst),
      .cli_addr (r_cli_addr),
      .cli_req  (r_cli_req),
      .cli_rdy  (r_cli_rdy),
      .cli_dout (r_cli_dout),
      .ram_addr (r_ram_addr),
      .ram_req  (r_ram_req),
      .ram_rdy  (r_ram_rdy),
      .ram_data (r_ram_data),
      .busy     (r_busy),
      .tmo_flag (r_tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic serve_main(input int c, input logic [24:0] a,
                             input logic [15:0] data, input int dly);
      int n;
      n = 0;
      while (d_ram_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_up", 32'(d_ram_req), 32'd1);
      repeat (dly) tick();
      chk("ram_addr", 32'(d_ram_addr), 32'(a));
      d_ram_rdy  = 1'b1;
      d_ram_data = data;
      tick();
      d_ram_rdy  = 1'b0;
      chk("cli_rdy", 32'(d_cli_rdy), 32'(1 << c));
      chk("cli_dout", 32'(d_cli_dout[16*c +: 16]), 32'(data));
      chk("req_dn", 32'(d_ram_req), 32'd0);
      d_cli_req[c] = 1'b0;
   endtask

   initial begin
      int n;
      logic [4:0] seen;
      rst        = 1'b1;
      d_cli_req  = '0;
      d_cli_addr = '0;
      d_ram_rdy  = 1'b0;
      d_ram_data = '0;
      r_cli_req  = '0;
      r_cli_addr = '0;
      r_ram_rdy  = 1'b0;
      r_ram_data = '0;
      tick();
      tick();

      chk("rst_ram_req", 32'(d_ram_req), 32'd0);
      chk("rst_ram_addr", 32'(d_ram_addr), 32'd0);
      chk("rst_cli_rdy", 32'(d_cli_rdy), 32'd0);
      chk("rst_busy", 32'(d_busy), 32'd0);
      chk("rst_tmo", 32'(d_tmo), 32'd0);
      for (int c = 0; c < 5; c++) begin
         chk("rst_dout", 32'(d_cli_dout[16*c +: 16]), 32'd0);
      end
      rst = 1'b0;
      tick();

      // single read, client 2, data after 4 ISSUE cycles
      d_cli_addr[50 +: 25] = 25'h000123;
      d_cli_req[2] = 1'b1;
      tick();
      chk("single_busy", 32'(d_busy), 32'd1);
      serve_main(2, 25'h000123, 16'hBEEF, 3);
      chk("single_d0", 32'(d_cli_dout[0 +: 16]), 32'd0);
      chk("single_d4", 32'(d_cli_dout[64 +: 16]), 32'd0);
      tick();
      chk("single_rdy_end", 32'(d_cli_rdy), 32'd0);
      chk("single_idle", 32'(d_busy), 32'd0);

      // fixed priority: clients 0, 3, 4 together
      d_cli_addr[0 +: 25]   = 25'h000100;
      d_cli_addr[75 +: 25]  = 25'h000300;
      d_cli_addr[100 +: 25] = 25'h000400;
      d_cli_req = 5'b11001;
      serve_main(0, 25'h000100, 16'hA000, 0);
      serve_main(3, 25'h000300, 16'hA003, 0);
      serve_main(4, 25'h000400, 16'hA004, 1);
      chk("prio_d2_hold", 32'(d_cli_dout[32 +: 16]), 32'hBEEF);

      // timeout on client 1
      d_cli_addr[25 +: 25] = 25'h001111;
      d_cli_req[1] = 1'b1;
      n = 0;
      while (d_ram_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      n = 0;
      while (d_ram_req === 1'b1 && n < 400) begin
         n++;
         tick();
      end
      chk("tmo_len", 32'(n), 32'd255);
      chk("tmo_rdy", 32'(d_cli_rdy), 32'b00010);
      chk("tmo_dout", 32'(d_cli_dout[16 +: 16]), 32'hFFFF);
      chk("tmo_flag", 32'(d_tmo), 32'd1);
      d_cli_req[1] = 1'b0;
      tick();
      tick();
      chk("tmo_sticky", 32'(d_tmo), 32'd1);
      chk("tmo_rdy_end", 32'(d_cli_rdy), 32'd0);

`ifdef XS_SDR_HITCACHE_EN
      d_cli_addr[0 +: 25] = 25'h000400;
      d_cli_req[0] = 1'b1;
      serve_main(0, 25'h000400, 16'h1234, 0);
      d_cli_req[0] = 1'b1;
      tick();
      chk("hit_noreq1", 32'(d_ram_req), 32'd0);
      tick();
      chk("hit_rdy", 32'(d_cli_rdy), 32'b00001);
      chk("hit_noreq2", 32'(d_ram_req), 32'd0);
      chk("hit_dout", 32'(d_cli_dout[0 +: 16]), 32'h1234);
      d_cli_req[0] = 1'b0;
      tick();
      d_cli_addr[0 +: 25] = 25'h000401;
      d_cli_req[0] = 1'b1;
      serve_main(0, 25'h000401, 16'h5678, 0);
      tick();
`endif

      // reset during ISSUE, then a stray ram_rdy
      d_cli_addr[100 +: 25] = 25'h004444;
      d_cli_req[4] = 1'b1;
      tick();
      tick();
      chk("mid_issue", 32'(d_ram_req), 32'd1);
      rst = 1'b1;
      d_cli_req = '0;
      tick();
      rst = 1'b0;
      chk("mid_ram_req", 32'(d_ram_req), 32'd0);
      chk("mid_ram_addr", 32'(d_ram_addr), 32'd0);
      chk("mid_busy", 32'(d_busy), 32'd0);
      chk("mid_tmo", 32'(d_tmo), 32'd0);
      chk("mid_dout", 32'(d_cli_dout[16 +: 16] | d_cli_dout[32 +: 16]), 32'd0);
      tick();
      d_ram_rdy  = 1'b1;
      d_ram_data = 16'h5A5A;
      seen = '0;
      tick();
      d_ram_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         seen = seen | d_cli_rdy;
         tick();
      end
      chk("stray_rdy", 32'(seen), 32'd0);
      chk("stray_busy", 32'(d_busy), 32'd0);
      chk("stray_dout", 32'(d_cli_dout[64 +: 16]), 32'd0);

      // round-robin: all five hold req for ten completions
      for (int c = 0; c < 5; c++) begin
         r_cli_addr[25*c +: 25] = 25'(32'h1000 + c * 16);
      end
      r_cli_req = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         int c;
         int rnd;
         c   = k % 5;
         rnd = k / 5;
         n   = 0;
         while (r_ram_req !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         chk("rr_addr", 32'(r_ram_addr), 32'(32'h1000 + c * 16 + rnd));
         r_ram_rdy  = 1'b1;
         r_ram_data = 16'(16'hC000 + k);
         tick();
         r_ram_rdy = 1'b0;
         chk("rr_rdy", 32'(r_cli_rdy), 32'(1 << c));
         chk("rr_dout", 32'(r_cli_dout[16*c +: 16]), 32'(16'hC000 + k));
         r_cli_addr[25*c +: 25] = 25'(32'h1000 + c * 16 + rnd + 1);
      end
      r_cli_req = '0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
